// File: rtl/fetch_pkg.sv
// Shared types and helpers for the warp fetch stage.
// Widths are maxima; each port zero-extends its own warp count and PC width.
package fetch_pkg;

  localparam int NUM_WARPS_DEF = 8;
  localparam int WARP_IDX_W    = $clog2(NUM_WARPS_DEF);
  localparam int MAX_WARPS     = 64;
  localparam int MAX_ADDR_W    = 64;

  typedef struct packed {
    logic                  valid;
    logic [MAX_ADDR_W-1:0] pc;
    logic [MAX_WARPS-1:0]  warp;
  } fetch_stage_t;

  function automatic logic is_onehot(input logic [MAX_WARPS-1:0] v);
    return (v != '0) && ((v & (v - MAX_WARPS'(1))) == '0);
  endfunction

  // One bit of a packed PC select: col[w] holds bit b of warp w's PC.
  function automatic logic onehot_mux(input logic [MAX_WARPS-1:0] sel,
                                      input logic [MAX_WARPS-1:0] col);
    return |(sel & col);
  endfunction

endpackage

// File: rtl/warp_fetch_pipe_if.sv
// Scheduler / I-cache / decode signals of the multi-port fetch stage.
interface warp_fetch_pipe_if #(
  parameter int NUM_WARPS = 8,
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int IDX_W     = 12
);
  logic [NUM_WARPS*ADDR_W-1:0]  pc_in;
  logic [NUM_PORTS*NUM_WARPS-1:0] grant;
  logic [NUM_WARPS-1:0]         flush;
  logic [NUM_PORTS*NUM_WARPS-1:0] issue_accept;
  logic [NUM_PORTS-1:0]         icache_en;
  logic [NUM_PORTS*IDX_W-1:0]   icache_addr;
  logic [NUM_PORTS*32-1:0]      icache_rdata;
  logic [NUM_PORTS-1:0]         out_valid;
  logic [NUM_PORTS-1:0]         out_ready;
  logic [NUM_PORTS*32-1:0]      out_instr;
  logic [NUM_PORTS*ADDR_W-1:0]  out_pc;
  logic [NUM_PORTS*NUM_WARPS-1:0] out_warp;

  modport master (
    output pc_in, grant, flush, icache_rdata, out_ready,
    input  issue_accept, icache_en, icache_addr, out_valid, out_instr, out_pc, out_warp
  );

  modport slave (
    input  pc_in, grant, flush, icache_rdata, out_ready,
    output issue_accept, icache_en, icache_addr, out_valid, out_instr, out_pc, out_warp
  );
endinterface

// File: rtl/fetch_port_pipe.sv
// One fetch port: warp PC select, I-cache request and ICACHE_LAT-deep tracking pipe.
module fetch_port_pipe
  import fetch_pkg::*;
#(
  parameter int NUM_WARPS  = 8,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 12,
  parameter int ICACHE_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_WARPS*ADDR_W-1:0] pc_in,
  input  logic [NUM_WARPS-1:0]        grant,
  input  logic [NUM_WARPS-1:0]        flush,
  input  logic                        out_ready,
  input  logic [31:0]                 icache_rdata,
  output logic [NUM_WARPS-1:0]        issue_accept,
  output logic                        icache_en,
  output logic [IDX_W-1:0]            icache_addr,
  output logic                        out_valid,
  output logic [31:0]                 out_instr,
  output logic [ADDR_W-1:0]           out_pc,
  output logic [NUM_WARPS-1:0]        out_warp
);

  fetch_stage_t         stage_q [ICACHE_LAT];
  fetch_stage_t         stage_d [ICACHE_LAT];
  fetch_stage_t         fresh;
  fetch_stage_t         tail;
  logic [MAX_WARPS-1:0] grant_x;
  logic [MAX_WARPS-1:0] flush_x;
  logic [MAX_WARPS-1:0] pc_col;
  logic [ADDR_W-1:0]    sel_pc;
  logic                 grant_ok;
  logic                 stall;
  logic                 unused_tail;

  assign grant_x  = MAX_WARPS'(grant);
  assign flush_x  = MAX_WARPS'(flush);
  assign grant_ok = is_onehot(grant_x);
  assign tail     = stage_q[ICACHE_LAT-1];

  assign out_valid   = tail.valid;
  assign out_pc      = ADDR_W'(tail.pc);
  assign out_warp    = NUM_WARPS'(tail.warp);
  assign out_instr   = icache_rdata;
  assign unused_tail = ^{tail.pc, tail.warp};

  assign stall     = out_valid & ~out_ready;
  assign icache_en = ~stall;

  // A malformed grant still drives warp 0's PC so the cache address stays defined.
  always_comb begin
    sel_pc = '0;
    pc_col = '0;
    for (int b = 0; b < ADDR_W; b++) begin
      pc_col = '0;
      for (int w = 0; w < NUM_WARPS; w++) pc_col[w] = pc_in[w*ADDR_W + b];
      sel_pc[b] = grant_ok ? onehot_mux(grant_x, pc_col) : pc_in[b];
    end
  end

  assign issue_accept = (grant_ok && !stall) ? (grant & ~flush) : '0;
  assign icache_addr  = IDX_W'(sel_pc - ADDR_W'(4));

  assign fresh = '{valid: |issue_accept, pc: MAX_ADDR_W'(sel_pc), warp: grant_x};

  // Flush is applied after the hold/advance choice so it wins over both.
  always_comb begin
    stage_d[0] = stall ? stage_q[0] : fresh;
    for (int s = 1; s < ICACHE_LAT; s++) stage_d[s] = stall ? stage_q[s] : stage_q[s-1];
    for (int s = 0; s < ICACHE_LAT; s++)
      if (|(stage_d[s].warp & flush_x)) stage_d[s].valid = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < ICACHE_LAT; s++) stage_q[s] <= '0;
    end else begin
      for (int s = 0; s < ICACHE_LAT; s++) stage_q[s] <= stage_d[s];
    end
  end

endmodule

// File: rtl/warp_fetch_pipe.sv
// Multi-port SIMT instruction fetch: NUM_PORTS independent fetch_port_pipe instances.
module warp_fetch_pipe
  import fetch_pkg::*;
#(
  parameter int NUM_WARPS  = NUM_WARPS_DEF,
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 12,
  parameter int ICACHE_LAT = 2
) (
  input logic              clk,
  input logic              rst_n,
  warp_fetch_pipe_if.slave bus
);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    fetch_port_pipe #(
      .NUM_WARPS  (NUM_WARPS),
      .ADDR_W     (ADDR_W),
      .IDX_W      (IDX_W),
      .ICACHE_LAT (ICACHE_LAT)
    ) u_port (
      .clk          (clk),
      .rst_n        (rst_n),
      .pc_in        (bus.pc_in),
      .grant        (bus.grant[p*NUM_WARPS +: NUM_WARPS]),
      .flush        (bus.flush),
      .out_ready    (bus.out_ready[p]),
      .icache_rdata (bus.icache_rdata[p*32 +: 32]),
      .issue_accept (bus.issue_accept[p*NUM_WARPS +: NUM_WARPS]),
      .icache_en    (bus.icache_en[p]),
      .icache_addr  (bus.icache_addr[p*IDX_W +: IDX_W]),
      .out_valid    (bus.out_valid[p]),
      .out_instr    (bus.out_instr[p*32 +: 32]),
      .out_pc       (bus.out_pc[p*ADDR_W +: ADDR_W]),
      .out_warp     (bus.out_warp[p*NUM_WARPS +: NUM_WARPS])
    );
  end

endmodule
